// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sequencer sharing one multi-cycle multiplier
// between NREQ requesters with registered start/ack/response pulses.
module mult_arbiter #(
  parameter int TBIT = 64,
  parameter int NREQ = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*TBIT-1:0] req_a,
  input  logic [NREQ*TBIT-1:0] req_b,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      resp_valid,
  output logic [TBIT-1:0]      resp_product,
  output logic                 busy,
  output logic [TBIT-1:0]      mult_a,
  output logic [TBIT-1:0]      mult_b,
  output logic                 mult_start,
  input  logic [TBIT-1:0]      mult_product,
  input  logic                 mult_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            done_q, done_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] rv_q, rv_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic [TBIT-1:0] a_q, a_d;
  logic [TBIT-1:0] b_q, b_d;
  logic [TBIT-1:0] prod_q, prod_d;

  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic            done_rise;
  int              scan;

  // Scan last+1 .. last+NREQ so the previous owner ranks lowest.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = (int'(last_q) + k) % NREQ;
      if (!grant_vld && req[IW'(scan)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(scan);
      end
    end
  end

  // A done level left over from an earlier op must not complete this one.
  assign done_rise = mult_done & ~done_q;
  assign done_d    = mult_done;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    ack_d   = '0;
    rv_d    = '0;
    start_d = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (grant_vld) begin
          a_d     = req_a[grant_idx*TBIT +: TBIT];
          b_d     = req_b[grant_idx*TBIT +: TBIT];
          owner_d = grant_idx;
          ack_d   = ONE << grant_idx;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      (state_q == S_ISSUE): begin
        state_d = S_WAIT;
      end
      (state_q == S_WAIT): begin
        if (done_rise) begin
          prod_d  = mult_product;
          last_d  = owner_q;
          rv_d    = ONE << owner_q;
          state_d = S_RESP;
        end
      end
      (state_q == S_RESP): begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ-1);
      owner_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= '0;
      rv_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  assign ack          = ack_q;
  assign resp_valid   = rv_q;
  assign resp_product = prod_q;
  assign busy         = busy_q;
  assign mult_a       = a_q;
  assign mult_b       = b_q;
  assign mult_start   = start_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and random checks of the shared-multiplier
// arbiter against a behavioural multiplier with adjustable latency.
module tb_mult_arbiter;
  localparam int TBIT = 64;
  localparam int NREQ = 4;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*TBIT-1:0] req_a = '0;
  logic [NREQ*TBIT-1:0] req_b = '0;
  logic [NREQ-1:0]      ack, resp_valid;
  logic [TBIT-1:0]      resp_product, mult_a, mult_b, mult_product;
  logic                 busy, mult_start, mult_done;

  int total = 0;
  int bad   = 0;

  bit              manual = 1'b0;
  logic            md_t = 1'b0;
  logic [TBIT-1:0] mp_t = '0;
  logic            md_m = 1'b0;
  logic [TBIT-1:0] mp_m = '0;
  logic [TBIT-1:0] pp = '0;
  int              cnt = 0;
  int              lat = 3;

  mult_arbiter #(.TBIT(TBIT), .NREQ(NREQ)) dut (
    .clock(clock), .reset(reset), .req(req),
    .req_a(req_a), .req_b(req_b), .ack(ack),
    .resp_valid(resp_valid), .resp_product(resp_product),
    .busy(busy), .mult_a(mult_a), .mult_b(mult_b),
    .mult_start(mult_start), .mult_product(mult_product),
    .mult_done(mult_done)
  );

  always #5 clock = ~clock;

  // Behavioural multiplier: done pulses for one cycle after lat cycles.
  always @(posedge clock) begin
    if (reset) begin
      md_m <= 1'b0;
      cnt  <= 0;
    end else if (mult_start) begin
      cnt  <= lat;
      pp   <= mult_a * mult_b;
      md_m <= 1'b0;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      cnt  <= 0;
      md_m <= 1'b1;
      mp_m <= pp;
    end else begin
      md_m <= 1'b0;
    end
  end

  assign mult_done    = manual ? md_t : md_m;
  assign mult_product = manual ? mp_t : mp_m;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [TBIT-1:0] a,
                        input logic [TBIT-1:0] b);
    req_a[i*TBIT +: TBIT] = a;
    req_b[i*TBIT +: TBIT] = b;
  endtask

  task automatic wait_ev(input bit want_resp, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if ((want_resp ? resp_valid : ack) != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input int i, input logic [TBIT-1:0] a,
                        input logic [TBIT-1:0] b,
                        output logic [NREQ-1:0] ack_o,
                        output logic [NREQ-1:0] rv_o,
                        output logic [TBIT-1:0] p_o);
    bit ok;
    set_op(i, a, b);
    req[i] = 1'b1;
    wait_ev(1'b0, ok);
    ack_o = ack;
    req[i] = 1'b0;
    wait_ev(1'b1, ok);
    rv_o = resp_valid;
    p_o  = resp_product;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    total++;
    if (ack !== '0) begin bad++; $display("FAIL reset_ack got=%h exp=0", ack); end
    total++;
    if (resp_valid !== '0) begin bad++; $display("FAIL reset_rv got=%h exp=0", resp_valid); end
    total++;
    if ({busy, mult_start} !== 2'b00) begin
      bad++; $display("FAIL reset_busy_start got=%b exp=00", {busy, mult_start});
    end
    total++;
    if ({mult_a, mult_b} !== '0) begin
      bad++; $display("FAIL reset_operands got=%h_%h exp=0", mult_a, mult_b);
    end
    total++;
    if (resp_product !== '0) begin
      bad++; $display("FAIL reset_product got=%h exp=0", resp_product);
    end
    reset = 1'b0;
    tick();
    total++;
    if ({busy, ack} !== '0) begin bad++; $display("FAIL idle_quiet got=%b exp=0", {busy, ack}); end
  endtask

  task automatic test_single();
    bit ok;
    set_op(0, 64'd2, 64'd3);
    req = 4'b0001;
    tick();
    total++;
    if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack got=%b exp=0001", ack); end
    total++;
    if ({mult_start, busy} !== 2'b11) begin
      bad++; $display("FAIL single_start_busy got=%b exp=11", {mult_start, busy});
    end
    req = '0;
    tick();
    total++;
    if ({mult_start, ack} !== '0) begin
      bad++; $display("FAIL single_pulse got=%b exp=0", {mult_start, ack});
    end
    wait_ev(1'b1, ok);
    total++;
    if (resp_valid !== 4'b0001) begin bad++; $display("FAIL single_rv got=%b exp=0001", resp_valid); end
    total++;
    if (resp_product !== 64'd6) begin bad++; $display("FAIL single_prod got=%h exp=6", resp_product); end
    tick();
    total++;
    if ({busy, resp_valid} !== '0) begin
      bad++; $display("FAIL single_end got=%b exp=0", {busy, resp_valid});
    end
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] a_o, r_o;
    logic [TBIT-1:0] p_o;
    run_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, a_o, r_o, p_o);
    total++;
    if ({a_o, r_o} !== 8'b0100_0100) begin
      bad++; $display("FAIL wrap1_hs got=%b_%b exp=0100_0100", a_o, r_o);
    end
    total++;
    if (p_o !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL wrap1_prod got=%h exp=fffffffffffffffd", p_o);
    end
    run_op(2, 64'hFFFF_FFFF_FFFF_FFEC, 64'd5, a_o, r_o, p_o);
    total++;
    if (p_o !== 64'hFFFF_FFFF_FFFF_FF9C) begin
      bad++; $display("FAIL wrap2_prod got=%h exp=ffffffffffffff9c", p_o);
    end
  endtask

  task automatic test_all_four();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [TBIT-1:0] prods [5] = '{64'd1000, 64'd1111, 64'd1224, 64'd1339, 64'd1000};
    logic [NREQ-1:0] expv;
    int na = 0;
    int nr = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 64'(10 + i), 64'(100 + i));
    req = '1;
    for (int c = 0; c < 200 && nr < 5; c++) begin
      tick();
      total++;
      if (mult_start !== (ack != '0)) begin
        bad++; $display("FAIL all4_start got=%b ack=%b", mult_start, ack);
      end
      if (ack != '0 && na < 5) begin
        expv = ONE << order[na];
        total++;
        if (ack !== expv) begin bad++; $display("FAIL all4_ack%0d got=%b exp=%b", na, ack, expv); end
        na++;
      end
      if (resp_valid != '0 && nr < 5) begin
        expv = ONE << order[nr];
        total++;
        if (resp_valid !== expv || resp_product !== prods[nr]) begin
          bad++;
          $display("FAIL all4_resp%0d got=%b/%0d exp=%b/%0d",
                   nr, resp_valid, resp_product, expv, prods[nr]);
        end
        if (nr == 4) req = '0;
        nr++;
      end
    end
    total++;
    if (nr != 5) begin bad++; $display("FAIL all4_count got=%0d exp=5", nr); end
  endtask

  task automatic test_rotation();
    bit ok;
    logic [NREQ-1:0] a_o, r_o;
    logic [TBIT-1:0] p_o;
    run_op(1, 64'd4, 64'd4, a_o, r_o, p_o);
    total++;
    if (a_o !== 4'b0010 || p_o !== 64'd16) begin
      bad++; $display("FAIL rot_first got=%b/%0d exp=0010/16", a_o, p_o);
    end
    set_op(0, 64'd6, 64'd7);
    set_op(1, 64'd8, 64'd9);
    req = 4'b0011;
    wait_ev(1'b0, ok);
    total++;
    if (ack !== 4'b0001) begin bad++; $display("FAIL rot_ack0 got=%b exp=0001", ack); end
    req = 4'b0010;
    wait_ev(1'b1, ok);
    total++;
    if (resp_valid !== 4'b0001 || resp_product !== 64'd42) begin
      bad++; $display("FAIL rot_resp0 got=%b/%0d exp=0001/42", resp_valid, resp_product);
    end
    wait_ev(1'b0, ok);
    total++;
    if (ack !== 4'b0010) begin bad++; $display("FAIL rot_ack1 got=%b exp=0010", ack); end
    req = '0;
    wait_ev(1'b1, ok);
    total++;
    if (resp_valid !== 4'b0010 || resp_product !== 64'd72) begin
      bad++; $display("FAIL rot_resp1 got=%b/%0d exp=0010/72", resp_valid, resp_product);
    end
  endtask

  task automatic test_stale_done();
    bit ok;
    manual = 1'b1;
    md_t   = 1'b1;
    mp_t   = 64'hDEAD;
    tick();
    tick();
    set_op(1, 64'd7, 64'd9);
    req = 4'b0010;
    wait_ev(1'b0, ok);
    total++;
    if (ack !== 4'b0010) begin bad++; $display("FAIL stale_ack got=%b exp=0010", ack); end
    req = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (resp_valid !== '0) begin bad++; $display("FAIL stale_early got=%b exp=0", resp_valid); end
    end
    md_t = 1'b0;
    tick();
    total++;
    if (resp_valid !== '0) begin bad++; $display("FAIL stale_fall got=%b exp=0", resp_valid); end
    mp_t = 64'd63;
    md_t = 1'b1;
    tick();
    total++;
    if (resp_valid !== 4'b0010 || resp_product !== 64'd63) begin
      bad++; $display("FAIL stale_resp got=%b/%0d exp=0010/63", resp_valid, resp_product);
    end
    md_t = 1'b0;
    tick();
    manual = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    logic [NREQ-1:0] a_o, r_o;
    logic [TBIT-1:0] p_o;
    lat = 8;
    set_op(3, 64'd5, 64'd6);
    req = 4'b1000;
    wait_ev(1'b0, ok);
    req = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({ack, resp_valid, busy, mult_start} !== '0) begin
      bad++; $display("FAIL rstw_ctrl got=%b exp=0", {ack, resp_valid, busy, mult_start});
    end
    total++;
    if ({mult_a, mult_b, resp_product} !== '0) begin
      bad++; $display("FAIL rstw_data got=%h_%h_%h exp=0", mult_a, mult_b, resp_product);
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      total++;
      if ({resp_valid, busy} !== '0) begin
        bad++; $display("FAIL rstw_ghost got=%b exp=0", {resp_valid, busy});
      end
    end
    lat = 3;
    run_op(3, 64'd5, 64'd6, a_o, r_o, p_o);
    total++;
    if ({a_o, r_o} !== 8'b1000_1000 || p_o !== 64'd30) begin
      bad++; $display("FAIL rstw_retry got=%b_%b/%0d exp=1000_1000/30", a_o, r_o, p_o);
    end
  endtask

  task automatic test_random_soak();
    logic [TBIT-1:0] exp_p [NREQ];
    bit              pend  [NREQ];
    int              waits [NREQ];
    int              idx;
    int              nops = 0;
    req = '0;
    for (int j = 0; j < NREQ; j++) begin
      pend[j]  = 1'b0;
      waits[j] = 0;
      exp_p[j] = '0;
    end
    tick();
    for (int c = 0; c < 10040; c++) begin
      tick();
      total++;
      if (mult_start !== (ack != '0)) begin
        bad++; $display("FAIL soak_start c=%0d got=%b ack=%b", c, mult_start, ack);
      end
      if (ack != '0) begin
        idx = 0;
        for (int j = 0; j < NREQ; j++) if (ack[j]) idx = j;
        total++;
        if (!$onehot(ack) || (ack & ~req) != '0 || pend[idx]) begin
          bad++; $display("FAIL soak_ack c=%0d got=%b req=%b", c, ack, req);
        end
        exp_p[idx] = req_a[idx*TBIT +: TBIT] * req_b[idx*TBIT +: TBIT];
        pend[idx]  = 1'b1;
        waits[idx] = 0;
        nops++;
        for (int j = 0; j < NREQ; j++) begin
          if (j != idx && req[j]) begin
            waits[j]++;
            total++;
            if (waits[j] >= NREQ) begin
              bad++; $display("FAIL soak_fair c=%0d req%0d waited=%0d max=%0d", c, j, waits[j], NREQ - 1);
            end
          end
        end
      end
      if (resp_valid != '0) begin
        idx = 0;
        for (int j = 0; j < NREQ; j++) if (resp_valid[j]) idx = j;
        total++;
        if (!$onehot(resp_valid) || !pend[idx] || resp_product !== exp_p[idx]) begin
          bad++;
          $display("FAIL soak_resp c=%0d got=%b/%h exp=%0d/%h",
                   c, resp_valid, resp_product, idx, exp_p[idx]);
        end
        pend[idx] = 1'b0;
      end
      lat = $urandom_range(1, 6);
      for (int j = 0; j < NREQ; j++) begin
        if (c >= 10000) begin
          req[j] = 1'b0;
        end else if (ack[j]) begin
          req[j] = 1'($urandom_range(0, 1));
          set_op(j, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        end else if (req[j]) begin
          if ($urandom_range(0, 15) == 0) begin
            req[j]   = 1'b0;
            waits[j] = 0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req[j]   = 1'b1;
          waits[j] = 0;
          set_op(j, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      total++;
      if (pend[j]) begin bad++; $display("FAIL soak_lost req%0d got=pending exp=answered", j); end
    end
    total++;
    if (nops < 500) begin bad++; $display("FAIL soak_ops got=%0d exp>=500", nops); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_all_four();
    test_rotation();
    test_stale_done();
    test_reset_in_wait();
    test_random_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle 64-bit `mult` unit (start/done handshake, truncated product) between `NREQ` requesters. It accepts one request at a time and issues the operands to the multiplier with a single-cycle `start`. It then waits for the multiplier's `done` and routes the low `TBIT` product bits back to the requester that owned the operation. It sits between the execute-stage clients and the single `mult` instance; the multiplier's `clock` and `reset` are the same nets.

## Interface
- `TBIT`, 64, operand/product width
- `NREQ`, 4, number of requesters (2..8); requester index width `IW = $clog2(NREQ)`

- `clock`  in  1  system clock, all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `req`  in  NREQ  per-requester request level
- `req_a`  in  NREQ*TBIT  packed multiplicands, requester i at [i*TBIT +: TBIT]
- `req_b`  in  NREQ*TBIT  packed multipliers, same packing
- `ack`  out  NREQ  one-hot, one-cycle pulse: request accepted, operands captured
- `resp_valid`  out  NREQ  one-hot, one-cycle pulse: product for requester i on `resp_product`
- `resp_product`  out  TBIT  registered product, valid only when `resp_valid` != 0
- `busy`  out  1  high in every state except IDLE
- `mult_a`, `mult_b`  out  TBIT  operands to multiplier, registered, stable from ISSUE through WAIT
- `mult_start`  out  1  one-cycle start pulse to multiplier
- `mult_product`  in  TBIT  multiplier result
- `mult_done`  in  1  multiplier done level

## Operation
- States: IDLE, ISSUE, WAIT, RESP; all outputs registered.
- IDLE: if `req` != 0, select the first asserted requester scanning `last+1, last+2, …` modulo `NREQ`. Capture its operands into `mult_a`/`mult_b` and its index into `owner`, then go to ISSUE. If `req` == 0, stay in IDLE.
- ISSUE: `mult_start`=1 and `ack[owner]`=1 for this cycle only, then go to WAIT.
- WAIT: completion is a rising edge of `mult_done` (`mult_done` & ~`done_q`, where `done_q` is `mult_done` registered every cycle). A `done` level held over from the previous operation never completes. On completion, capture `mult_product` into `resp_product`, set `last` = `owner`, and go to RESP.
- RESP: `resp_valid[owner]`=1 for this cycle only, then go to IDLE.
- Arithmetic: the product is the low `TBIT` bits of `a*b`; signed operands wrap identically, so no sign handling is done in the arbiter.
- Requester rules:
  - Hold `req` and operands stable until `ack`.
  - Dropping `req` before `ack` withdraws the request with no side effect.
  - `req` still high in the cycle after `ack` is a new request.
  - Operand changes after `ack` are ignored.
- Fairness: a requester that was just served has lowest priority on the next arbitration, so any continuously requesting client is served within `NREQ` operations.
- Reset values: state=IDLE, `last`=NREQ-1 (requester 0 wins the first arbitration), `owner`=0, `done_q`=0. `ack`, `resp_valid`, `mult_start` and `busy` are 0. `mult_a`, `mult_b` and `resp_product` are 0.
- Reset mid-operation (any state): return to the reset values at the next edge and drop the in-flight operation. No `resp_valid` is issued for it; its requester must re-request.
- `mult_done` rising while in IDLE, ISSUE or RESP: ignored, with only `done_q` updated.

## Timing
- `req[i]` high and sampled in IDLE at edge E: ISSUE follows in cycle E+1 with `ack[i]`=1 and `mult_start`=1, and WAIT begins in E+2.
- Multiplier `done` rises and is sampled at edge D: `resp_valid[i]` and `resp_product` are valid in cycle D+1, and IDLE resumes in D+2.
- Minimum requester latency from `req` to `resp_valid` is multiplier latency + 3 cycles.
- Back-to-back: the next `mult_start` comes no earlier than 3 cycles after the previous `done` rise (RESP, IDLE, ISSUE).
- `busy` rises the cycle after a winning `req` is sampled and falls in the cycle after RESP.

## Test plan
- Single request: requester 0, a=2, b=3 → one `ack[0]` pulse and one `mult_start` pulse, then `resp_valid[0]` with `resp_product`=6. No other `ack`/`resp_valid` bits assert.
- Wrap-around: requester 2, a=64'hFFFF_FFFF_FFFF_FFFF (−1), b=3 → product 64'hFFFF_FFFF_FFFF_FFFD; then a=−20, b=5 → 64'hFFFF_FFFF_FFFF_FF9C.
- All four requesting continuously from reset with distinct operands → grants in order 0,1,2,3,0. Each `resp_valid[i]` carries that requester's product; `mult_start` never asserts while `busy` is in WAIT.
- Priority rotation: after requester 1 is served, `req`=4'b0011 → requester 0 is granted next, then 1.
- Stale done: the multiplier holds `done` high after an operation while a new request is issued immediately → no `resp_valid` until `done` falls and rises again, and the result equals the new a*b.
- Reset in WAIT: assert `reset` one cycle mid-operation → next cycle all outputs are 0 and the state is IDLE. No `resp_valid` appears for the aborted operation; a re-request completes correctly.
- Random soak: 10 000 cycles of random `req` and 64-bit operands, checked against a scoreboard using a*b truncated to 64 bits. Every `ack` gets exactly one matching `resp_valid`, and no requester waits longer than `NREQ` operations.
